// File: rtl/sprite_pkg.sv
// -----------------------------------------------------------------------------
// sprite_pkg
// Shared types and constants for the sprite motion engine.
//   mode_t     : run-time motion mode (IDLE / KEY / BOUNCE / CHASE)
//   dir_t      : decoded steering direction of a WASD keycode
//   vel_t      : signed per-axis velocity in pixels per frame
//   KEY_*      : USB HID keycodes for W, A, S, D
//   DEF_*      : default playfield geometry and motion limits
// Optional build macro used by the consumers of this package: SPRITE_WRAP_EN.
// -----------------------------------------------------------------------------
package sprite_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        KEY    = 2'd1,
        BOUNCE = 2'd2,
        CHASE  = 2'd3
    } mode_t;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_LEFT  = 3'd2,
        DIR_DOWN  = 3'd3,
        DIR_RIGHT = 3'd4
    } dir_t;

    // Four bits hold +/-7, comfortably above any sensible MAX_STEP.
    typedef logic signed [3:0] vel_t;

    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_S = 8'h16;
    localparam logic [7:0] KEY_D = 8'h07;

    localparam int DEF_POS_W       = 10;
    localparam int DEF_X_MIN       = 0;
    localparam int DEF_X_MAX       = 639;
    localparam int DEF_Y_MIN       = 0;
    localparam int DEF_Y_MAX       = 479;
    localparam int DEF_X_CENTER    = 320;
    localparam int DEF_Y_CENTER    = 240;
    localparam int DEF_SIZE        = 32;
    localparam int DEF_MAX_STEP    = 4;
    localparam int DEF_RAMP_FRAMES = 8;

    function automatic dir_t key_to_dir(input logic [7:0] code);
        case (code)
            KEY_W:   return DIR_UP;
            KEY_A:   return DIR_LEFT;
            KEY_S:   return DIR_DOWN;
            KEY_D:   return DIR_RIGHT;
            default: return DIR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/sprite_motion_ctrl_axis.sv
// -----------------------------------------------------------------------------
// sprite_axis
// Purely combinational single-axis mover: next = pos + vel, then edge handling
// against the legal centre range [LO, HI].
//   i_pos        : current centre coordinate (unsigned)
//   i_vel        : velocity to apply this frame (signed)
//   i_allow_wrap : 1 = wrap to the opposite edge, 0 = clamp and reflect
//   o_pos        : coordinate after this frame
//   o_vel        : velocity after this frame (sign forced away from a hit edge)
//   o_hit        : this axis crossed an edge this frame
// The wrap path is only ever enabled by the top level when SPRITE_WRAP_EN is
// defined; otherwise i_allow_wrap is tied low and the axis reflects.
// -----------------------------------------------------------------------------
module sprite_axis
    import sprite_pkg::*;
#(
    parameter int POS_W = DEF_POS_W,
    parameter int LO    = DEF_X_MIN + DEF_SIZE,
    parameter int HI    = DEF_X_MAX - DEF_SIZE
) (
    input  logic [POS_W-1:0] i_pos,
    input  vel_t             i_vel,
    input  logic             i_allow_wrap,
    output logic [POS_W-1:0] o_pos,
    output vel_t             o_vel,
    output logic             o_hit
);

    // Two extra bits: one for sign, one of headroom, so pos + vel can never
    // wrap around before it is compared with the limits.
    localparam int NW = POS_W + 2;
    localparam logic signed [NW-1:0] LO_S  = NW'(LO);
    localparam logic signed [NW-1:0] HI_S  = NW'(HI);
    localparam logic signed [NW-1:0] ONE_S = NW'(1);

    logic signed [NW-1:0] w_vel_ext;
    logic signed [NW-1:0] w_next;
    vel_t                 w_mag;

    assign w_vel_ext = {{(NW-4){i_vel[3]}}, i_vel};
    assign w_next    = $signed({2'b00, i_pos}) + w_vel_ext;
    assign w_mag     = (i_vel < 0) ? -i_vel : i_vel;

    // NOTE: every output gets a default before any branch, so no path through
    // this block can leave a value unassigned and infer a latch.
    always_comb begin
        o_pos = POS_W'(w_next);
        o_vel = i_vel;
        o_hit = 1'b0;
        if (w_next > HI_S) begin
            o_hit = 1'b1;
            if (i_allow_wrap) begin
                // Overshoot past HI re-enters at LO with the same remainder.
                o_pos = POS_W'(LO_S + (w_next - HI_S - ONE_S));
            end else begin
                o_pos = POS_W'(HI_S);
                o_vel = -w_mag;
            end
        end else if (w_next < LO_S) begin
            o_hit = 1'b1;
            if (i_allow_wrap) begin
                o_pos = POS_W'(HI_S - (LO_S - w_next - ONE_S));
            end else begin
                o_pos = POS_W'(LO_S);
                o_vel = w_mag;
            end
        end
    end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// -----------------------------------------------------------------------------
// sprite_motion_ctrl
// Per-frame motion engine for one sprite. Chooses a velocity from the current
// mode, moves each axis through sprite_axis, and keeps the ramp, bounce and
// at-target bookkeeping.
// Ports:
//   frame_clk            : frame tick, all state changes on its rising edge
//   Reset                : asynchronous, active-high, clears all state
//   en                   : frame enable; 0 freezes everything, bounce_pulse=0
//   mode                 : 0=IDLE 1=KEY 2=BOUNCE 3=CHASE
//   keycode              : USB HID keycode (W/A/S/D steer in KEY mode)
//   target_x / target_y  : chase target, clamped into the legal range
//   pos_x / pos_y        : registered sprite centre
//   size                 : constant half-extent SIZE
//   vel_x / vel_y        : registered signed velocity
//   bounce_pulse         : an edge was hit on the last enabled frame
//   bounce_cnt           : edge-hit frames, modulo 256
//   at_target            : CHASE only, centre equals the clamped target
// Build macro: SPRITE_WRAP_EN -- when defined, KEY and BOUNCE modes wrap to the
// opposite edge instead of reflecting; CHASE always clamps.
// -----------------------------------------------------------------------------
module sprite_motion_ctrl
    import sprite_pkg::*;
#(
    parameter int POS_W       = DEF_POS_W,
    parameter int X_MIN       = DEF_X_MIN,
    parameter int X_MAX       = DEF_X_MAX,
    parameter int Y_MIN       = DEF_Y_MIN,
    parameter int Y_MAX       = DEF_Y_MAX,
    parameter int X_CENTER    = DEF_X_CENTER,
    parameter int Y_CENTER    = DEF_Y_CENTER,
    parameter int SIZE        = DEF_SIZE,
    parameter int MAX_STEP    = DEF_MAX_STEP,
    parameter int RAMP_FRAMES = DEF_RAMP_FRAMES
) (
    input  logic                    frame_clk,
    input  logic                    Reset,
    input  logic                    en,
    input  logic [1:0]              mode,
    input  logic [7:0]              keycode,
    input  logic [POS_W-1:0]        target_x,
    input  logic [POS_W-1:0]        target_y,
    output logic [POS_W-1:0]        pos_x,
    output logic [POS_W-1:0]        pos_y,
    output logic [POS_W-1:0]        size,
    output logic signed [3:0]       vel_x,
    output logic signed [3:0]       vel_y,
    output logic                    bounce_pulse,
    output logic [7:0]              bounce_cnt,
    output logic                    at_target
);

    localparam int NW = POS_W + 2;

    localparam logic [POS_W-1:0] X_LO = POS_W'(X_MIN + SIZE);
    localparam logic [POS_W-1:0] X_HI = POS_W'(X_MAX - SIZE);
    localparam logic [POS_W-1:0] Y_LO = POS_W'(Y_MIN + SIZE);
    localparam logic [POS_W-1:0] Y_HI = POS_W'(Y_MAX - SIZE);

    localparam logic signed [NW-1:0] MAX_S = NW'(MAX_STEP);

    // The ramp counter saturates exactly where the step reaches MAX_STEP, so
    // step = 1 + cnt / RAMP_FRAMES never needs a separate min().
    localparam int CNT_MAX = (MAX_STEP - 1) * RAMP_FRAMES;
    localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX_V = CNT_W'(CNT_MAX);

    // ---------------------------------------------------------------- state
    logic [POS_W-1:0] r_pos_x;
    logic [POS_W-1:0] r_pos_y;
    vel_t             r_vel_x;
    vel_t             r_vel_y;
    dir_t             r_dir;
    logic [CNT_W-1:0] r_cnt;
    logic             r_bounce_pulse;
    logic [7:0]       r_bounce_cnt;
    logic             r_at_target;

    // ---------------------------------------------------------------- wires
    mode_t            w_mode;
    dir_t             w_key_dir;
    dir_t             w_dir_next;
    logic [CNT_W-1:0] w_cnt_next;
    vel_t             w_step;
    vel_t             w_vx_cmd;
    vel_t             w_vy_cmd;
    logic [POS_W-1:0] w_tgt_x;
    logic [POS_W-1:0] w_tgt_y;
    logic             w_allow_wrap;
    logic [POS_W-1:0] w_ax_pos_x;
    logic [POS_W-1:0] w_ax_pos_y;
    vel_t             w_ax_vel_x;
    vel_t             w_ax_vel_y;
    logic             w_hit_x;
    logic             w_hit_y;
    logic             w_hit;
    logic             w_at_target;

    assign w_mode    = mode_t'(mode);
    assign w_key_dir = key_to_dir(keycode);

    // Signed chase velocity for one axis: move straight at the target but
    // never faster than MAX_STEP, so the last step lands exactly on it.
    function automatic vel_t chase_vel(input logic [POS_W-1:0] tgt,
                                       input logic [POS_W-1:0] pos);
        logic signed [NW-1:0] d;
        d = $signed({2'b00, tgt}) - $signed({2'b00, pos});
        if (d > MAX_S) begin
            return vel_t'(MAX_STEP);
        end else if (d < -MAX_S) begin
            return vel_t'(-MAX_STEP);
        end
        return vel_t'(d);
    endfunction

    // ------------------------------------------------------- target clamping
    // A clamped target is a legal position, so chasing it never reaches the
    // axis edge logic and can never be counted as a bounce.
    always_comb begin
        w_tgt_x = target_x;
        if (target_x < X_LO) begin
            w_tgt_x = X_LO;
        end else if (target_x > X_HI) begin
            w_tgt_x = X_HI;
        end
        w_tgt_y = target_y;
        if (target_y < Y_LO) begin
            w_tgt_y = Y_LO;
        end else if (target_y > Y_HI) begin
            w_tgt_y = Y_HI;
        end
    end

    // ----------------------------------------------------------------- ramp
    // Counter grows only while the same WASD direction is held in KEY mode;
    // any other key, a direction change or leaving KEY mode restarts it.
    always_comb begin
        w_dir_next = DIR_NONE;
        w_cnt_next = '0;
        if ((w_mode == KEY) && (w_key_dir != DIR_NONE)) begin
            w_dir_next = w_key_dir;
            if (w_key_dir == r_dir) begin
                w_cnt_next = (r_cnt == CNT_MAX_V) ? r_cnt : r_cnt + 1'b1;
            end
        end
    end

    assign w_step = vel_t'(32'(w_cnt_next) / RAMP_FRAMES + 1);

    // ------------------------------------------------------ velocity command
    always_comb begin
        w_vx_cmd = r_vel_x;
        w_vy_cmd = r_vel_y;
        unique case (w_mode)
            IDLE: begin
                w_vx_cmd = '0;
                w_vy_cmd = '0;
            end
            KEY: begin
                // A non-WASD code leaves the current velocity untouched.
                unique case (w_key_dir)
                    DIR_UP: begin
                        w_vx_cmd = '0;
                        w_vy_cmd = -w_step;
                    end
                    DIR_DOWN: begin
                        w_vx_cmd = '0;
                        w_vy_cmd = w_step;
                    end
                    DIR_LEFT: begin
                        w_vx_cmd = -w_step;
                        w_vy_cmd = '0;
                    end
                    DIR_RIGHT: begin
                        w_vx_cmd = w_step;
                        w_vy_cmd = '0;
                    end
                    default: begin
                    end
                endcase
            end
            BOUNCE: begin
                // Only a stalled axis is kicked; a moving one keeps its speed.
                if (r_vel_x == 0) begin
                    w_vx_cmd = vel_t'(1);
                end
                if (r_vel_y == 0) begin
                    w_vy_cmd = vel_t'(1);
                end
            end
            CHASE: begin
                w_vx_cmd = chase_vel(w_tgt_x, r_pos_x);
                w_vy_cmd = chase_vel(w_tgt_y, r_pos_y);
            end
            default: begin
            end
        endcase
    end

`ifdef SPRITE_WRAP_EN
    assign w_allow_wrap = (w_mode == KEY) || (w_mode == BOUNCE);
`else
    assign w_allow_wrap = 1'b0;
`endif

    // ------------------------------------------------------------- the axes
    sprite_axis #(
        .POS_W (POS_W),
        .LO    (X_MIN + SIZE),
        .HI    (X_MAX - SIZE)
    ) u_axis_x (
        .i_pos        (r_pos_x),
        .i_vel        (w_vx_cmd),
        .i_allow_wrap (w_allow_wrap),
        .o_pos        (w_ax_pos_x),
        .o_vel        (w_ax_vel_x),
        .o_hit        (w_hit_x)
    );

    sprite_axis #(
        .POS_W (POS_W),
        .LO    (Y_MIN + SIZE),
        .HI    (Y_MAX - SIZE)
    ) u_axis_y (
        .i_pos        (r_pos_y),
        .i_vel        (w_vy_cmd),
        .i_allow_wrap (w_allow_wrap),
        .o_pos        (w_ax_pos_y),
        .o_vel        (w_ax_vel_y),
        .o_hit        (w_hit_y)
    );

    // A corner hit is still a single bounce event for this frame.
    assign w_hit = w_hit_x | w_hit_y;

    // Evaluated on the post-move position so the flag rises on the frame
    // that lands on the target.
    assign w_at_target = (w_mode == CHASE) &&
                         (w_ax_pos_x == w_tgt_x) && (w_ax_pos_y == w_tgt_y);

    // ------------------------------------------------------------ registers
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_pos_x        <= POS_W'(X_CENTER);
            r_pos_y        <= POS_W'(Y_CENTER);
            r_vel_x        <= '0;
            r_vel_y        <= '0;
            r_dir          <= DIR_NONE;
            r_cnt          <= '0;
            r_bounce_pulse <= 1'b0;
            r_bounce_cnt   <= '0;
            r_at_target    <= 1'b0;
        end else if (en) begin
            r_pos_x        <= w_ax_pos_x;
            r_pos_y        <= w_ax_pos_y;
            r_vel_x        <= w_ax_vel_x;
            r_vel_y        <= w_ax_vel_y;
            r_dir          <= w_dir_next;
            r_cnt          <= w_cnt_next;
            r_bounce_pulse <= w_hit;
            r_bounce_cnt   <= r_bounce_cnt + 8'(w_hit);
            r_at_target    <= w_at_target;
        end else begin
            r_bounce_pulse <= 1'b0;
        end
    end

    assign pos_x        = r_pos_x;
    assign pos_y        = r_pos_y;
    assign size         = POS_W'(SIZE);
    assign vel_x        = r_vel_x;
    assign vel_y        = r_vel_y;
    assign bounce_pulse = r_bounce_pulse;
    assign bounce_cnt   = r_bounce_cnt;
    assign at_target    = r_at_target;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sprite_motion_ctrl
// Scoreboard bench for sprite_motion_ctrl with default parameters. The driver
// applies one frame per negative edge, advances an integer reference model of
// the motion rules and queues the expected outputs; the monitor pops one entry
// after each rising edge and compares. Directed segments pin known values
// (ramp, chase, corner bounce), then randomized segments exercise all modes.
// Honors SPRITE_WRAP_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_sprite_motion_ctrl;

    localparam int LO_X = 32;
    localparam int HI_X = 607;
    localparam int LO_Y = 32;
    localparam int HI_Y = 447;
    localparam int MAXS = 4;
    localparam int RAMP = 8;

    logic              frame_clk = 1'b0;
    logic              Reset;
    logic              en;
    logic [1:0]        mode;
    logic [7:0]        keycode;
    logic [9:0]        target_x;
    logic [9:0]        target_y;
    logic [9:0]        pos_x;
    logic [9:0]        pos_y;
    logic [9:0]        size;
    logic signed [3:0] vel_x;
    logic signed [3:0] vel_y;
    logic              bounce_pulse;
    logic [7:0]        bounce_cnt;
    logic              at_target;

    sprite_motion_ctrl dut (
        .frame_clk    (frame_clk),
        .Reset        (Reset),
        .en           (en),
        .mode         (mode),
        .keycode      (keycode),
        .target_x     (target_x),
        .target_y     (target_y),
        .pos_x        (pos_x),
        .pos_y        (pos_y),
        .size         (size),
        .vel_x        (vel_x),
        .vel_y        (vel_y),
        .bounce_pulse (bounce_pulse),
        .bounce_cnt   (bounce_cnt),
        .at_target    (at_target)
    );

    always #5 frame_clk = ~frame_clk;

    typedef struct {
        int px;
        int py;
        int vx;
        int vy;
        int pulse;
        int bcnt;
        int at;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state.
    int m_px, m_py, m_vx, m_vy, m_cnt, m_key, m_bcnt, m_pulse, m_at;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic int absi(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic bit is_wasd(input int k);
        return (k == 'h1A) || (k == 'h04) || (k == 'h16) || (k == 'h07);
    endfunction

    task automatic model_reset();
        m_px = 320; m_py = 240; m_vx = 0; m_vy = 0;
        m_cnt = 0; m_key = -1; m_bcnt = 0; m_pulse = 0; m_at = 0;
    endtask

    task automatic move_axis(inout int p, inout int v, input int lo, input int hi,
                             input bit wrap, output bit hit);
        int n;
        n = p + v;
        hit = 1'b0;
        if (n > hi) begin
            hit = 1'b1;
            if (wrap) p = lo + (n - hi - 1);
            else begin p = hi; v = -absi(v); end
        end else if (n < lo) begin
            hit = 1'b1;
            if (wrap) p = hi - (lo - n - 1);
            else begin p = lo; v = absi(v); end
        end else begin
            p = n;
        end
    endtask

    task automatic model_frame(input bit e, input int md, input int key,
                               input int tx, input int ty);
        int step, ctx, cty;
        bit hx, hy, wrap;
        if (!e) begin
            m_pulse = 0;
            return;
        end
        ctx = clampi(tx, LO_X, HI_X);
        cty = clampi(ty, LO_Y, HI_Y);
        if (md == 1 && is_wasd(key)) begin
            m_cnt = (key == m_key) ? m_cnt + 1 : 0;
            m_key = key;
        end else begin
            m_cnt = 0;
            m_key = -1;
        end
        step = 1 + m_cnt / RAMP;
        if (step > MAXS) step = MAXS;
        case (md)
            0: begin m_vx = 0; m_vy = 0; end
            1: case (key)
                   'h1A: begin m_vx = 0; m_vy = -step; end
                   'h16: begin m_vx = 0; m_vy = step; end
                   'h04: begin m_vx = -step; m_vy = 0; end
                   'h07: begin m_vx = step; m_vy = 0; end
                   default: ;
               endcase
            2: begin
                if (m_vx == 0) m_vx = 1;
                if (m_vy == 0) m_vy = 1;
            end
            default: begin
                m_vx = clampi(ctx - m_px, -MAXS, MAXS);
                m_vy = clampi(cty - m_py, -MAXS, MAXS);
            end
        endcase
`ifdef SPRITE_WRAP_EN
        wrap = (md == 1) || (md == 2);
`else
        wrap = 1'b0;
`endif
        move_axis(m_px, m_vx, LO_X, HI_X, wrap, hx);
        move_axis(m_py, m_vy, LO_Y, HI_Y, wrap, hy);
        m_pulse = (hx || hy) ? 1 : 0;
        m_bcnt  = (m_bcnt + m_pulse) % 256;
        m_at    = (md == 3 && m_px == ctx && m_py == cty) ? 1 : 0;
    endtask

    task automatic drive_frame(input bit e, input int md, input int key,
                               input int tx, input int ty);
        exp_t x;
        @(negedge frame_clk);
        en       = e;
        mode     = 2'(md);
        keycode  = 8'(key);
        target_x = 10'(tx);
        target_y = 10'(ty);
        model_frame(e, md, key, tx, ty);
        x = '{m_px, m_py, m_vx, m_vy, m_pulse, m_bcnt, m_at};
        exp_q.push_back(x);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 4 && exp_q.size() != 0; i++) begin
            @(posedge frame_clk);
            #2;
        end
        if (exp_q.size() != 0) begin
            check("scoreboard_drain", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    // Asynchronous reset between edges; outputs must clear without a clock.
    task automatic apply_reset();
        @(negedge frame_clk);
        en    = 1'b0;
        Reset = 1'b1;
        #1;
        check("rst_pos_x", pos_x, 320);
        check("rst_pos_y", pos_y, 240);
        check("rst_vel_x", vel_x, 0);
        check("rst_vel_y", vel_y, 0);
        check("rst_bounce_cnt", bounce_cnt, 0);
        check("rst_bounce_pulse", bounce_pulse, 0);
        check("rst_at_target", at_target, 0);
        model_reset();
        #1;
        Reset = 1'b0;
    endtask

    function automatic int rand_key();
        case ($urandom_range(0, 5))
            0: return 'h1A;
            1: return 'h04;
            2: return 'h16;
            3: return 'h07;
            4: return 0;
            default: return int'($urandom_range(0, 255));
        endcase
    endfunction

    // Monitor: one expected entry per driven frame, compared after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge frame_clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("pos_x", pos_x, e.px);
                check("pos_y", pos_y, e.py);
                check("vel_x", vel_x, e.vx);
                check("vel_y", vel_y, e.vy);
                check("bounce_pulse", bounce_pulse, e.pulse);
                check("bounce_cnt", bounce_cnt, e.bcnt);
                check("at_target", at_target, e.at);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset    = 1'b1;
        en       = 1'b0;
        mode     = 2'd0;
        keycode  = 8'h00;
        target_x = '0;
        target_y = '0;
        model_reset();
        #12;
        check("size", size, 32);
        apply_reset();

        // IDLE holds the reset position.
        for (int f = 0; f < 20; f++) drive_frame(1'b1, 0, 0, 0, 0);
        wait_drain();
        check("idle_pos_x", pos_x, 320);
        check("idle_pos_y", pos_y, 240);
        check("idle_bounce_cnt", bounce_cnt, 0);

        // Held D: eight frames at step 1, eight at step 2, then W restarts.
        for (int f = 0; f < 8; f++) drive_frame(1'b1, 1, 'h07, 0, 0);
        wait_drain();
        check("ramp8_pos_x", pos_x, 328);
        for (int f = 0; f < 8; f++) drive_frame(1'b1, 1, 'h07, 0, 0);
        wait_drain();
        check("ramp16_pos_x", pos_x, 344);
        check("ramp16_vel_x", vel_x, 2);
        drive_frame(1'b1, 1, 'h1A, 0, 0);
        wait_drain();
        check("w_vel_x", vel_x, 0);
        check("w_vel_y", vel_y, -1);
        check("w_pos_y", pos_y, 239);

        // Chase from centre to (330,235): lands on frame 3.
        apply_reset();
        for (int f = 0; f < 3; f++) drive_frame(1'b1, 3, 0, 330, 235);
        wait_drain();
        check("chase_pos_x", pos_x, 330);
        check("chase_pos_y", pos_y, 235);
        check("chase_at_target", at_target, 1);
        drive_frame(1'b1, 3, 0, 330, 235);
        wait_drain();
        check("chase_rest_vel_x", vel_x, 0);
        check("chase_rest_vel_y", vel_y, 0);

        // Park next to the corner, then bounce both axes on the same frame.
        apply_reset();
        for (int f = 0; f < 80; f++) drive_frame(1'b1, 3, 0, 606, 446);
        drive_frame(1'b1, 2, 0, 0, 0);
        drive_frame(1'b1, 2, 0, 0, 0);
        wait_drain();
        check("corner_pulse", bounce_pulse, 1);
        check("corner_bounce_cnt", bounce_cnt, 1);
`ifdef SPRITE_WRAP_EN
        check("corner_pos_x", pos_x, 32);
        check("corner_vel_x", vel_x, 1);
`else
        check("corner_pos_x", pos_x, 607);
        check("corner_vel_x", vel_x, -1);
`endif
        drive_frame(1'b1, 2, 0, 0, 0);
        wait_drain();
        check("corner_pulse_drop", bounce_pulse, 0);

        // Randomized segments across all modes, with a reset in the middle.
        for (int s = 0; s < 60; s++) begin
            int md, len, key, tx, ty;
            md  = int'($urandom_range(0, 3));
            len = int'($urandom_range(10, 150));
            key = rand_key();
            tx  = int'($urandom_range(0, 1023));
            ty  = int'($urandom_range(0, 1023));
            if (s == 30) apply_reset();
            for (int f = 0; f < len; f++) begin
                if ($urandom_range(0, 7) == 0) key = rand_key();
                if ($urandom_range(0, 31) == 0) begin
                    tx = int'($urandom_range(0, 1023));
                    ty = int'($urandom_range(0, 1023));
                end
                drive_frame($urandom_range(0, 9) != 0, md, key, tx, ty);
            end
        end
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
